// File: rtl/oqpsk_mod.sv
// oqpsk_mod: O-QPSK modulator producing half-sine shaped I/Q baseband samples.
// Chip pairs enter through a one-entry holding register; Q lags I by one chip
// (half an I symbol). Optional build macro OQPSK_DBG_EN adds the burst_cnt
// output, an 8-bit wrapping count of completed bursts.
module oqpsk_mod #(
  parameter int SPS   = 8,
  parameter int DIV   = 4,
  parameter int WIDTH = 5,
  parameter int AMP   = 15
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [1:0]              chip_pair,
  input  logic                    validation,
  output logic                    pret,
  output logic signed [WIDTH-1:0] i_out,
  output logic signed [WIDTH-1:0] q_out,
  output logic                    sample_valid
`ifdef OQPSK_DBG_EN
  ,
  output logic [7:0]              burst_cnt
`endif
);

  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] HALF     = PW'(SPS / 2);
  localparam logic [PW-1:0] PH_LAST  = PW'(SPS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Elaboration-time half-sine: round(AMP*sin(pi*k/SPS)) via a Taylor series
  // folded into [0, pi/2].
  function automatic int lut_val(input int k);
    real x;
    real x2;
    real s;
    x = 3.14159265358979 * real'(k) / real'(SPS);
    if (x > 1.5707963267949) x = 3.14159265358979 - x;
    x2 = x * x;
    s = x * (1.0 - x2 / 6.0 * (1.0 - x2 / 20.0 * (1.0 - x2 / 42.0 *
        (1.0 - x2 / 72.0 * (1.0 - x2 / 110.0)))));
    return int'(real'(AMP) * s);
  endfunction

  logic signed [WIDTH-1:0] lut [SPS];
  for (genvar k = 0; k < SPS; k++) begin : g_lut
    assign lut[k] = WIDTH'(lut_val(k));
  end

  state_e                  state_q, state_d;
  logic                    hold_full_q, hold_full_d;
  logic [1:0]              hold_data_q, hold_data_d;
  logic [DW-1:0]           div_q, div_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    i_chip_q, i_chip_d;
  logic                    pend_chip_q, pend_chip_d;
  logic                    q_chip_q, q_chip_d;
  logic                    i_active_q, i_active_d;
  logic                    q_active_q, q_active_d;
  logic signed [WIDTH-1:0] i_out_q, i_out_d;
  logic signed [WIDTH-1:0] q_out_q, q_out_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    tick;
  logic                    consume;
  logic                    accept;
  logic [PW-1:0]           q_idx;

  // Handshake: a pair transfers on a rising edge where validation=1 and
  // pret=1; pret is simply "holding register empty". Offers made while pret=0
  // are ignored, and a consume at a tick frees the register for the next edge.
  assign pret   = ~hold_full_q;
  assign accept = validation & ~hold_full_q;
  assign q_idx  = (phase_q >= HALF) ? (phase_q - HALF) : (phase_q + HALF);

  // Next-state, tick scheduling, chip loading and sample computation.
  always_comb begin
    state_d        = state_q;
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    div_d          = div_q;
    phase_d        = phase_q;
    i_chip_d       = i_chip_q;
    pend_chip_d    = pend_chip_q;
    q_chip_d       = q_chip_q;
    i_active_d     = i_active_q;
    q_active_d     = q_active_q;
    i_out_d        = i_out_q;
    q_out_d        = q_out_q;
    sample_valid_d = 1'b0;
    tick           = 1'b0;
    consume        = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d   = '0;
        phase_d = '0;
        if (hold_full_q) state_d = S_RUN;
      end
      default: begin
        tick  = (div_q == '0);
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        if (tick) begin
          sample_valid_d = 1'b1;
          phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
          // Start of an I symbol: take the next pair, or underrun into FLUSH.
          if (state_q == S_RUN && phase_q == '0) begin
            if (hold_full_q) begin
              i_chip_d    = hold_data_q[1];
              pend_chip_d = hold_data_q[0];
              i_active_d  = 1'b1;
              consume     = 1'b1;
            end else begin
              i_active_d = 1'b0;
              state_d    = S_FLUSH;
            end
          end
          // Mid-symbol: Q picks up the chip paired with the current I chip.
          if (phase_q == HALF) begin
            q_chip_d = pend_chip_q;
            if (state_q == S_RUN) begin
              q_active_d = 1'b1;
            end else begin
              q_active_d     = 1'b0;
              state_d        = S_IDLE;
              sample_valid_d = 1'b0;
              phase_d        = '0;
              div_d          = '0;
            end
          end
          i_out_d = i_active_d ? (i_chip_d ? lut[phase_q] : -lut[phase_q]) : '0;
          q_out_d = q_active_d ? (q_chip_d ? lut[q_idx] : -lut[q_idx]) : '0;
        end
      end
    endcase
    if (consume) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = chip_pair;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      hold_full_q    <= 1'b0;
      hold_data_q    <= 2'b00;
      div_q          <= '0;
      phase_q        <= '0;
      i_chip_q       <= 1'b0;
      pend_chip_q    <= 1'b0;
      q_chip_q       <= 1'b0;
      i_active_q     <= 1'b0;
      q_active_q     <= 1'b0;
      i_out_q        <= '0;
      q_out_q        <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_full_q    <= hold_full_d;
      hold_data_q    <= hold_data_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      i_chip_q       <= i_chip_d;
      pend_chip_q    <= pend_chip_d;
      q_chip_q       <= q_chip_d;
      i_active_q     <= i_active_d;
      q_active_q     <= q_active_d;
      i_out_q        <= i_out_d;
      q_out_q        <= q_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign i_out        = i_out_q;
  assign q_out        = q_out_q;
  assign sample_valid = sample_valid_q;

`ifdef OQPSK_DBG_EN
  logic [7:0] burst_cnt_q, burst_cnt_d;

  // Count completed bursts (FLUSH -> IDLE), wrapping at 8 bits.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == S_FLUSH && state_d == S_IDLE) burst_cnt_d = burst_cnt_q + 8'd1;
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) burst_cnt_q <= 8'd0;
    else         burst_cnt_q <= burst_cnt_d;
  end

  assign burst_cnt = burst_cnt_q;
`endif

endmodule
